// File: rtl/lfsr_pkg.sv
// Shared constants for the configurable LFSR family: step-structure
// encodings and known-good default tap masks and seeds.
package lfsr_pkg;

  // Step structure selected by the mode input.
  localparam logic MODE_FIBONACCI = 1'b0;
  localparam logic MODE_GALOIS    = 1'b1;

  // Maximal-length tap masks (bit k-1 set means tap k).
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;        // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;     // x^16+x^14+x^13+x^11+1
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003; // x^32+x^22+x^2+x^1+1

  // Default reset / recovery seeds.
  localparam logic [7:0]  LFSR_SEED_8  = 8'h01;
  localparam logic [15:0] LFSR_SEED_16 = 16'h0001;
  localparam logic [31:0] LFSR_SEED_32 = 32'h0000_0001;

endpackage

// File: rtl/lfsr_next_state.sv
// Single-step next-state function for the LFSR. Purely combinational so a
// multi-step variant can chain several copies.
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = LFSR_TAPS_8
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  output logic [WIDTH-1:0] next
);

  // Galois injects the polynomial {TAPS[WIDTH-2:0], 1} when the MSB falls out.
  localparam logic [WIDTH-1:0] GALOIS_POLY = {TAPS[WIDTH-2:0], 1'b1};

  // Select between the Fibonacci and Galois step equations.
  always_comb begin
    next = '0;
    if (mode == MODE_GALOIS) begin
      next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GALOIS_POLY : '0);
    end else begin
      next = {state[WIDTH-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_configuravel.sv
// Configurable LFSR with runtime Fibonacci/Galois selection, seed loading
// with zero-seed protection, and measurement of the sequence period.
//
// Control per clock edge, highest priority first: reset, load, enable, hold.
// load and enable are plain level inputs sampled every edge; there is no
// handshake, and a load that coincides with enable suppresses the step.
module lfsr_configuravel
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_8,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] period_q;
  logic             wrap_q;
  logic             lockup_q;

  logic [WIDTH-1:0] next_state;
  logic             seed_zero;
  logic [WIDTH-1:0] load_value;
  logic             hit_start;

  lfsr_next_state #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .state (state_q),
    .mode  (mode),
    .next  (next_state)
  );

  // An all-zero seed would lock the register at zero; substitute SEED.
  always_comb begin
    seed_zero  = (seed_in == '0);
    load_value = seed_zero ? SEED : seed_in;
    hit_start  = (next_state == start_q);
  end

  // Register update: load beats enable; hold only clears the wrap pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= SEED;
      start_q  <= SEED;
      count_q  <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else if (load) begin
      state_q <= load_value;
      start_q <= load_value;
      count_q <= '0;
      wrap_q  <= 1'b0;
      if (seed_zero) begin
        lockup_q <= 1'b1;
      end
    end else if (enable) begin
      state_q <= next_state;
      if (hit_start) begin
        wrap_q   <= 1'b1;
        period_q <= count_q + ONE;
        count_q  <= '0;
      end else begin
        wrap_q  <= 1'b0;
        count_q <= count_q + ONE;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // Output map; bit_out is taken straight from the current state.
  always_comb begin
    state   = state_q;
    bit_out = state_q[WIDTH-1];
    wrap    = wrap_q;
    period  = period_q;
    lockup  = lockup_q;
  end

endmodule

// File: tb/tb_lfsr_configuravel.sv
// Testbench for lfsr_configuravel: directed vector table, hand-written
// multi-cycle sequences, randomized run against a reference model, and a
// full-period run of a 16-bit instance.
module tb_lfsr_configuravel;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // 8-bit instance signals
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       mode = 1'b0;
  logic [7:0] state;
  logic       bit_out;
  logic       wrap;
  logic [7:0] period;
  logic       lockup;

  // 16-bit instance signals
  logic        enable16 = 1'b0;
  logic        load16 = 1'b0;
  logic [15:0] seed_in16 = 16'h0000;
  logic        mode16 = 1'b0;
  logic [15:0] state16;
  logic        bit_out16;
  logic        wrap16;
  logic [15:0] period16;
  logic        lockup16;

  lfsr_configuravel dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .load    (load),
    .seed_in (seed_in),
    .mode    (mode),
    .state   (state),
    .bit_out (bit_out),
    .wrap    (wrap),
    .period  (period),
    .lockup  (lockup)
  );

  lfsr_configuravel #(
    .WIDTH (16),
    .TAPS  (16'hB400),
    .SEED  (16'h0001)
  ) dut16 (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable16),
    .load    (load16),
    .seed_in (seed_in16),
    .mode    (mode16),
    .state   (state16),
    .bit_out (bit_out16),
    .wrap    (wrap16),
    .period  (period16),
    .lockup  (lockup16)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on integers: Fibonacci shifts in the parity of the tapped bits;
  // Galois shifts left and, if a one fell off the top, XORs in the
  // polynomial (taps moved up one place with the constant term set).
  localparam int M_TAPS = 'hB8;
  localparam int M_SEED = 1;

  int m_state, m_start, m_count, m_period, m_wrap, m_lockup;

  function automatic int m_next(input int s, input logic md);
    int shifted;
    shifted = (s * 2) % 256;
    if (md == 1'b0) begin
      return shifted + ($countones(s & M_TAPS) % 2);
    end
    if (s >= 128) begin
      return shifted ^ (((M_TAPS * 2) % 256) + 1);
    end
    return shifted;
  endfunction

  task automatic m_reset();
    m_state = M_SEED; m_start = M_SEED; m_count = 0;
    m_period = 0; m_wrap = 0; m_lockup = 0;
  endtask

  task automatic m_edge(input logic ld, input logic en, input int seed, input logic md);
    int n;
    if (ld) begin
      m_state = (seed == 0) ? M_SEED : seed;
      m_start = m_state;
      m_count = 0;
      m_wrap  = 0;
      if (seed == 0) m_lockup = 1;
    end else if (en) begin
      n = m_next(m_state, md);
      m_count = (m_count + 1) % 256;
      if (n == m_start) begin
        m_wrap = 1; m_period = m_count; m_count = 0;
      end else begin
        m_wrap = 0;
      end
      m_state = n;
    end else begin
      m_wrap = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b0; load = 1'b0; seed_in = 8'h00; mode = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Step n times with enable high; the only wrap must be on the last step.
  task automatic run_to_wrap(input int n, input string name);
    int early = 0;
    int wraps = 0;
    enable = 1'b1; load = 1'b0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (wrap) begin
        wraps++;
        if (i != n) early++;
      end
    end
    check({name, "_early_wrap"}, early, 0);
    check({name, "_wrap_count"}, wraps, 1);
    check({name, "_wrap_last"}, wrap, 1);
    check({name, "_period"}, period, 8'd255);
    check({name, "_state"}, state, 8'h01);
    enable = 1'b0;
    tick();
    check({name, "_wrap_one_cycle"}, wrap, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ld;
    logic       en;
    logic [7:0] seed;
    logic       md;
    logic [7:0] st;
    logic       wr;
    logic       lk;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0] gal_exp[8];
    int held_bad;
    int w16_early;
    int w16_count;

    vecs[0]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h04, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'h33, 1'b0, 8'h33, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h66, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hCC, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hE9, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'hD3, 1'b0, 1'b1};

    gal_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h71};

    // Reset values
    do_reset();
    #1;
    check("rst_state", state, 8'h01);
    check("rst_period", period, 8'h00);
    check("rst_wrap", wrap, 0);
    check("rst_lockup", lockup, 0);
    check("rst_bit_out", bit_out, 0);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      load = vecs[i].ld; enable = vecs[i].en;
      seed_in = vecs[i].seed; mode = vecs[i].md;
      tick();
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      check($sformatf("vec%0d_bit_out", i), bit_out, vecs[i].st[7]);
      check($sformatf("vec%0d_wrap", i), wrap, vecs[i].wr);
      check($sformatf("vec%0d_lockup", i), lockup, vecs[i].lk);
    end
    load = 1'b0; enable = 1'b0;
    // Lockup stays set across further valid loads.
    load = 1'b1; seed_in = 8'h77;
    tick();
    load = 1'b0;
    check("lockup_sticky", lockup, 1);

    // Fibonacci full period
    do_reset();
    mode = 1'b0;
    run_to_wrap(255, "fib255");

    // Hold with enable low: state and count frozen, period still 255 later
    enable = 1'b1;
    tick(); tick(); tick();
    check("hold_pre_state", state, 8'h08);
    enable = 1'b0;
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state !== 8'h08 || wrap !== 1'b0) held_bad++;
    end
    check("hold_frozen", held_bad, 0);
    run_to_wrap(252, "hold_resume");

    // Galois from 0x01
    do_reset();
    mode = 1'b1; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("gal_seq%0d", i), state, gal_exp[i]);
    end
    run_to_wrap(247, "gal255");

    // Async reset mid-run with lockup and period set
    load = 1'b1; seed_in = 8'h00;
    tick();
    load = 1'b0; enable = 1'b1;
    tick(); tick();
    check("pre_areset_lockup", lockup, 1);
    check("pre_areset_period", period, 8'd255);
    #2;
    reset = 1'b0;
    #1;
    check("areset_state", state, 8'h01);
    check("areset_period", period, 8'h00);
    check("areset_lockup", lockup, 0);
    check("areset_wrap", wrap, 0);
    @(negedge clock);
    reset = 1'b1;
    enable = 1'b0;

    // Load equal to current start restarts the count without a wrap
    mode = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    load = 1'b1; seed_in = 8'h01;
    tick();
    load = 1'b0;
    check("load_eq_start_state", state, 8'h01);
    check("load_eq_start_wrap", wrap, 0);
    run_to_wrap(255, "load_eq_start");

    // Randomized run against the model
    do_reset();
    m_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] exp_s;
      load = ($urandom_range(63) == 0);
      enable = ($urandom_range(3) != 0);
      seed_in = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255));
      if ($urandom_range(199) == 0) mode = ~mode;
      m_edge(load, enable, int'(seed_in), mode);
      exp_q.push_back(8'(m_state));
      tick();
      exp_s = exp_q.pop_front();
      check("rand_state", state, exp_s);
      check("rand_bit_out", bit_out, exp_s[7]);
      check("rand_wrap", wrap, m_wrap);
      check("rand_period", period, m_period);
      check("rand_lockup", lockup, m_lockup);
    end
    load = 1'b0; enable = 1'b0;

    // 16-bit full period
    do_reset();
    #1;
    check("w16_rst_state", state16, 16'h0001);
    enable16 = 1'b1;
    w16_early = 0;
    w16_count = 0;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (wrap16) begin
        w16_count++;
        if (i != 65535) w16_early++;
      end
    end
    enable16 = 1'b0;
    check("w16_early_wrap", w16_early, 0);
    check("w16_wrap_count", w16_count, 1);
    check("w16_wrap_last", wrap16, 1);
    check("w16_period", period16, 16'hFFFF);
    check("w16_state", state16, 16'h0001);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
